// File: rtl/fir_mac_bank.sv
// fir_mac_bank: single-channel FIR, one serial multiply-accumulate per clock, BANKS writable coefficient sets.
// Define FIR_SAT_EN to saturate the output and add out_sat; without it the output wraps to OUT_W bits.
module fir_mac_bank #(
  parameter  int DATA_W = 8,
  parameter  int COEF_W = 8,
  parameter  int TAPS   = 16,
  parameter  int BANKS  = 4,
  parameter  int OUT_W  = 8,
  parameter  int SHIFT  = 7,
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int TAP_W  = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [BANK_W-1:0]        bank_sel,
  input  logic                     coef_we,
  input  logic [BANK_W-1:0]        coef_bank,
  input  logic [TAP_W-1:0]         coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
`ifdef FIR_SAT_EN
  output logic                     out_sat,
`endif
  output logic                     busy
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + TAP_W;
  localparam int RND_W  = ACC_W + 1;
  // Half an output LSB, added before the shift so the result rounds half up.
  localparam logic signed [RND_W-1:0] RND_C = (RND_W'(1) << SHIFT) >> 1;
`ifdef FIR_SAT_EN
  localparam logic signed [RND_W-1:0] OUT_MAX = RND_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [RND_W-1:0] OUT_MIN = ~OUT_MAX;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_e;

  state_e                     state_q, state_d;
  logic signed [DATA_W-1:0]   line_q [TAPS];
  logic signed [DATA_W-1:0]   line_d [TAPS];
  logic signed [COEF_W-1:0]   coef_q [BANKS][TAPS];
  logic signed [COEF_W-1:0]   coef_d [BANKS][TAPS];
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [TAP_W-1:0]           tap_q, tap_d;
  logic [BANK_W-1:0]          bank_q, bank_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]    out_data_q, out_data_d;
`ifdef FIR_SAT_EN
  logic                       out_sat_q, out_sat_d;
`endif

  logic signed [COEF_W-1:0]   mac_coef;
  logic signed [PROD_W-1:0]   prod;
  logic signed [RND_W-1:0]    rnd_val;
  logic signed [RND_W-1:0]    r_val;
  logic                       wr_ok;

  // NOTE: every signal written here gets its default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    coef_d      = coef_q;
    acc_d       = acc_q;
    tap_d       = tap_q;
    bank_d      = bank_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
`ifdef FIR_SAT_EN
    out_sat_d   = out_sat_q;
`endif

    // An out-of-range bank reads as all-zero coefficients.
    mac_coef = (int'(bank_q) < BANKS) ? coef_q[bank_q][tap_q] : '0;
    prod     = PROD_W'(line_q[tap_q]) * PROD_W'(mac_coef);
    rnd_val  = RND_W'(acc_q) + RND_C;
    r_val    = rnd_val >>> SHIFT;
    wr_ok    = coef_we && (int'(coef_bank) < BANKS) && (int'(coef_addr) < TAPS);

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          line_d[0] = in_data;
          for (int k = 1; k < TAPS; k++) line_d[k] = line_q[k-1];
          bank_d  = bank_sel;
          acc_d   = '0;
          tap_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        tap_d = tap_q + TAP_W'(1);
        if (tap_q == TAP_W'(TAPS - 1)) state_d = S_OUT;
      end
      S_OUT: begin
        out_valid_d = 1'b1;
`ifdef FIR_SAT_EN
        if (r_val > OUT_MAX) begin
          out_data_d = OUT_MAX[OUT_W-1:0];
          out_sat_d  = 1'b1;
        end else if (r_val < OUT_MIN) begin
          out_data_d = OUT_MIN[OUT_W-1:0];
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = r_val[OUT_W-1:0];
          out_sat_d  = 1'b0;
        end
`else
        out_data_d = r_val[OUT_W-1:0];
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The MAC above reads coef_q, so a write to the tap being read lands after that read.
    if (wr_ok) coef_d[coef_bank][coef_addr] = coef_wdata;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      tap_q       <= '0;
      bank_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef FIR_SAT_EN
      out_sat_q   <= 1'b0;
`endif
      for (int k = 0; k < TAPS; k++) line_q[k] <= '0;
      // NOTE: the coefficient store is deliberately reset, so it stays in flops rather than a RAM macro.
      for (int b = 0; b < BANKS; b++) begin
        for (int k = 0; k < TAPS; k++) coef_q[b][k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      coef_q      <= coef_d;
      acc_q       <= acc_d;
      tap_q       <= tap_d;
      bank_q      <= bank_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef FIR_SAT_EN
      out_sat_q   <= out_sat_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef FIR_SAT_EN
  assign out_sat   = out_sat_q;
`endif

endmodule

// File: tb/tb_fir_mac_bank.sv
// Self-checking bench for fir_mac_bank: dot-product reference model, per-cycle compare, directed and random stimulus.
// Build with +define+FIR_SAT_EN to exercise the saturating variant.
module tb_fir_mac_bank;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 16;
  localparam int BANKS  = 4;
  localparam int OUT_W  = 8;
  localparam int SHIFT  = 7;
  localparam int BANK_W = 2;
  localparam int TAP_W  = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data = '0;
  logic [BANK_W-1:0]        bank_sel = '0;
  logic                     coef_we = 1'b0;
  logic [BANK_W-1:0]        coef_bank = '0;
  logic [TAP_W-1:0]         coef_addr = '0;
  logic signed [COEF_W-1:0] coef_wdata = '0;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_data;
  logic                     busy;
`ifdef FIR_SAT_EN
  logic                     out_sat;
`endif

  always #5 clk = ~clk;

  fir_mac_bank #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS),
    .BANKS(BANKS), .OUT_W(OUT_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .bank_sel(bank_sel),
    .coef_we(coef_we), .coef_bank(coef_bank), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(out_valid), .out_data(out_data),
`ifdef FIR_SAT_EN
    .out_sat(out_sat),
`endif
    .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: on accept it snapshots the bank, tracks writes that land before each tap's
  // read, and forms the dot product when the result is due TAPS+1 edges after accept.
  int     m_coef [BANKS][TAPS];
  int     m_line [TAPS];
  int     m_snap [TAPS];
  bit     m_active, m_ready_pre, m_exp_valid, m_exp_sat;
  int     m_bank, m_exp_data;
  longint m_now, m_acc_edge, m_sum, m_r;
  logic signed [OUT_W-1:0] m_wrap;

  function automatic void m_clear();
    for (int b = 0; b < BANKS; b++)
      for (int k = 0; k < TAPS; k++) m_coef[b][k] = 0;
    for (int k = 0; k < TAPS; k++) m_line[k] = 0;
    m_active    = 1'b0;
    m_exp_valid = 1'b0;
    m_exp_data  = 0;
    m_exp_sat   = 1'b0;
  endfunction

  initial begin
    m_clear();
    m_now = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_clear();
      end else begin
        m_now++;
        m_ready_pre = !m_active;
        m_exp_valid = 1'b0;
        if (m_active && m_now == m_acc_edge + TAPS + 1) begin
          m_sum = 0;
          for (int k = 0; k < TAPS; k++) m_sum += longint'(m_line[k]) * m_snap[k];
          m_r = (m_sum + ((SHIFT > 0) ? (64'sd1 <<< (SHIFT - 1)) : 64'sd0)) >>> SHIFT;
`ifdef FIR_SAT_EN
          if (m_r > 2 ** (OUT_W - 1) - 1) begin
            m_exp_data = 2 ** (OUT_W - 1) - 1;
            m_exp_sat  = 1'b1;
          end else if (m_r < -(2 ** (OUT_W - 1))) begin
            m_exp_data = -(2 ** (OUT_W - 1));
            m_exp_sat  = 1'b1;
          end else begin
            m_exp_data = int'(m_r);
            m_exp_sat  = 1'b0;
          end
`else
          m_wrap     = m_r[OUT_W-1:0];
          m_exp_data = m_wrap;
`endif
          m_exp_valid = 1'b1;
          m_active    = 1'b0;
        end
        if (in_valid && m_ready_pre) begin
          for (int k = TAPS - 1; k > 0; k--) m_line[k] = m_line[k-1];
          m_line[0] = in_data;
          m_bank    = bank_sel;
          for (int k = 0; k < TAPS; k++) m_snap[k] = m_coef[bank_sel][k];
          m_acc_edge = m_now;
          m_active   = 1'b1;
        end
        if (coef_we && coef_bank < BANKS && coef_addr < TAPS) begin
          if (m_active && int'(coef_bank) == m_bank && m_now <= m_acc_edge + coef_addr)
            m_snap[coef_addr] = coef_wdata;
          m_coef[coef_bank][coef_addr] = coef_wdata;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("out_valid", out_valid, m_exp_valid);
      check("in_ready", in_ready, !m_active);
      check("busy", busy, m_active);
      check("out_data", out_data, m_exp_data);
`ifdef FIR_SAT_EN
      check("out_sat", out_sat, m_exp_sat);
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_coef(input int b, input int a, input int w);
    coef_we    = 1'b1;
    coef_bank  = BANK_W'(b);
    coef_addr  = TAP_W'(a);
    coef_wdata = COEF_W'(w);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic fill_bank(input int b, input int w);
    for (int k = 0; k < TAPS; k++) write_coef(b, k, w);
  endtask

  // Sends one sample; wr_at>0 writes coefficient wa of the same bank on edge accept+wr_at.
  task automatic send(input int d, input int b, input int wr_at, input int wa, input int wd,
                      output int res);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("send_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    bank_sel = BANK_W'(b);
    tick();
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
    bank_sel = BANK_W'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      if (wr_at > 0 && n == wr_at - 1) begin
        coef_we    = 1'b1;
        coef_bank  = BANK_W'(b);
        coef_addr  = TAP_W'(wa);
        coef_wdata = COEF_W'(wd);
      end
      tick();
      coef_we = 1'b0;
      n++;
    end
    check("latency", n, TAPS + 1);
    res = out_data;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  int res, cnt;
  bit acc_now;

  initial begin
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    #2 rst_n = 1'b1;
    tick();

    // Impulse of 127 through coef k+1: (127*(k+1)+64)>>>7 == k+1.
    for (int k = 0; k < TAPS; k++) write_coef(0, k, k + 1);
    for (int j = 0; j < TAPS; j++) begin
      send((j == 0) ? 127 : 0, 0, 0, 0, 0, res);
      check("impulse", res, j + 1);
    end

    // DC 64 through bank1 all 2: n-th output is (128n+64)>>>7 == n; bank_sel toggles mid-MAC inside send.
    fill_bank(1, 2);
    for (int n = 1; n <= TAPS; n++) begin
      send(64, 1, 0, 0, 0, res);
      check("bank1_dc", res, n);
    end

    // Reset while a sample is in MAC: no out_valid for it.
    in_valid = 1'b1;
    in_data  = DATA_W'(50);
    bank_sel = 2'd1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    pulse_reset();
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) cnt++;
      tick();
    end
    check("abort_no_valid", cnt, 0);

    // Saturation from a zeroed delay line: -127, then -254 clipped to -128 or wrapped to 2.
    fill_bank(2, 127);
    send(-128, 2, 0, 0, 0, res);
    check("sat_first", res, -127);
`ifdef FIR_SAT_EN
    check("sat_first_flag", out_sat, 0);
`endif
    send(-128, 2, 0, 0, 0, res);
`ifdef FIR_SAT_EN
    check("sat_second", res, -128);
    check("sat_second_flag", out_sat, 1);
`else
    check("wrap_second", res, 2);
`endif

    // Bank3 was cleared by the reset.
    send(100, 3, 0, 0, 0, res);
    check("coef_cleared", res, 0);

    // Writes landing while tap 3 is read: tap 15 picks up the new value, tap 3 keeps the old one.
    pulse_reset();
    fill_bank(0, 1);
    for (int j = 0; j < TAPS; j++) send(64, 0, 0, 0, 0, res);
    send(64, 0, 4, 15, 33, res);
    check("wr_future_tap", res, 24);
    send(64, 0, 4, 3, 100, res);
    check("wr_same_tap_old", res, 24);
    send(64, 0, 0, 0, 0, res);
    check("wr_same_tap_next", res, 74);

    // Backpressure: in_valid held high for 90 cycles gives exactly 5 accepts.
    in_valid = 1'b1;
    in_data  = DATA_W'($urandom);
    bank_sel = BANK_W'($urandom);
    cnt = 0;
    for (int i = 0; i < 90; i++) begin
      acc_now = in_ready;
      if (acc_now) cnt++;
      tick();
      if (acc_now) begin
        in_data  = DATA_W'($urandom);
        bank_sel = BANK_W'($urandom);
      end
    end
    in_valid = 1'b0;
    check("backpressure_accepts", cnt, 5);
    repeat (25) tick();

    // Random traffic with random coefficient writes and one mid-run reset.
    for (int c = 0; c < 2500; c++) begin
      coef_we    = ($urandom_range(0, 4) == 0);
      coef_bank  = BANK_W'($urandom);
      coef_addr  = TAP_W'($urandom);
      coef_wdata = COEF_W'($urandom);
      if (!in_valid) begin
        in_valid = ($urandom_range(0, 2) == 0);
        in_data  = DATA_W'($urandom);
        bank_sel = BANK_W'($urandom);
      end
      acc_now = in_valid && in_ready;
      tick();
      if (acc_now) in_valid = 1'b0;
      if (c == 1200) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    coef_we  = 1'b0;
    in_valid = 1'b0;
    repeat (25) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_mac_bank.md
Name: fir_mac_bank

Overview:
- Parametrised single-channel FIR filter for the waveform-filtering path.
- Computes with a serial multiply-accumulate (MAC), one tap per clock.
- Holds BANKS run-time-writable coefficient sets; a bank is selected per sample, extending the fixed ROM select of the earlier FIR top.
- Input uses a valid/ready handshake and output is a one-cycle valid pulse, so the block sits between a waveform source and any downstream consumer.

Parameters:
- DATA_W, 8: signed input sample width.
- COEF_W, 8: signed coefficient width.
- TAPS, 16: number of taps; minimum 2.
- BANKS, 4: number of coefficient banks; minimum 1.
- OUT_W, 8: signed output width.
- SHIFT, 7: arithmetic right shift applied to the accumulator before output; minimum 0.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  signed input sample.
- bank_sel  in  max(1,clog2(BANKS))  coefficient bank for this sample; sampled on accept.
- coef_we  in  1  coefficient write strobe.
- coef_bank  in  max(1,clog2(BANKS))  bank to write.
- coef_addr  in  clog2(TAPS)  tap index to write.
- coef_wdata  in  COEF_W  signed coefficient value.
- out_valid  out  1  one-cycle pulse; out_data is new.
- out_data  out  OUT_W  signed filtered sample; held until the next out_valid.
- busy  out  1  high in MAC or OUT state.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0.
  - Delay line, accumulator, tap counter and latched bank are cleared.
  - All coefficients of all banks are cleared to 0.
- Reset asserted mid-operation aborts the in-flight sample immediately; no out_valid is produced for it.
- Accept condition: in_valid && in_ready. in_ready=1 only in IDLE.
- On accept:
  - in_data shifts into line[0]; line[k] moves to line[k+1]; the oldest sample is dropped.
  - bank_sel is latched; acc is cleared; tap counter k=0; state goes to MAC.
- MAC state:
  - Each cycle, acc += line[k]*coef[bank][k] (full-precision signed), then k++.
  - After k=TAPS-1 the state goes to OUT.
  - Accumulator width is DATA_W+COEF_W+clog2(TAPS); it cannot overflow.
- OUT state (1 cycle):
  - r = (acc + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, i.e. round half up.
  - out_data <= r reduced to OUT_W (see optional feature); out_valid <= 1 for one cycle; state goes to IDLE.
- Latency: accept on the edge at cycle 0 gives out_valid high at cycle TAPS+1.
- Throughput: at most one sample every TAPS+2 cycles; in_ready is high again in the cycle out_valid is high.
- Handshake:
  - While busy, in_valid is not accepted; the source holds in_data.
  - Changes on bank_sel outside the accept cycle have no effect.
- Coefficient writes:
  - Accepted in any state; take effect on the next edge.
  - A MAC read of the same bank/address in the same cycle uses the old value.
  - coef_addr >= TAPS or coef_bank >= BANKS: the write is ignored.
- Simultaneous accept and coef_we: both occur; the write does not affect tap 0 of that sample if it lands on the same cycle as its read.

Optional Feature:
- Macro: FIR_SAT_EN.
- Defined:
  - r is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Extra output port out_sat (1 bit) is high alongside out_valid when clipping occurred; it is held otherwise and resets to 0.
- Undefined:
  - r is truncated to its low OUT_W bits (two's-complement wrap).
  - Port out_sat does not exist.

Test Plan:
- Reset: hold rst_n=0, then release → in_ready=1, out_valid=0, out_data=0, busy=0. Assert rst_n during MAC → no out_valid; the next impulse response starts from a zeroed delay line.
- Impulse (TAPS=16, SHIFT=0, bank0 coef[k]=k+1): feed 1 followed by 15 zeros → out_data=1,2,…,16. Each out_valid arrives exactly 17 cycles after its accept.
- Bank select (bank1 all coef=1, SHIFT=0): DC input 4 with bank_sel=1 → outputs 4,8,…,64. Toggle bank_sel to 0 mid-MAC → the current result is unchanged.
- Saturation (bank2 coef=127, SHIFT=7): input -128 repeated → outputs -127, then -128 with out_sat=1 when FIR_SAT_EN is defined. Without FIR_SAT_EN the second output is 2 (wrapped).
- Backpressure: hold in_valid=1 continuously → exactly one accept per 18 cycles; in_ready=0 throughout MAC/OUT; no sample is lost or duplicated.
- Coefficient write during MAC: write bank0 tap 15 while tap 3 is being processed → the current output uses the new value. A write to tap 3 in the same cycle as its read uses the old value.
